// File: rtl/ecc_pkg.sv
// Shared constants and types for the post-SECDED error monitor.
// Error-type encodings match the decoder's error_type output.
package ecc_pkg;

  localparam int DATA_W    = 8;
  localparam int SYN_W     = 4;
  localparam int CODE_W    = 13;
  localparam int LOG_IDX_W = 8;

  localparam logic [1:0] ERR_NONE   = 2'b00;
  localparam logic [1:0] ERR_SINGLE = 2'b01;
  localparam logic [1:0] ERR_DOUBLE = 2'b10;
  localparam logic [1:0] ERR_PARITY = 2'b11;

  // Log entry layout at the default index width.
  typedef struct packed {
    logic [SYN_W-1:0]     syndrome;
    logic [1:0]           error_type;
    logic [LOG_IDX_W-1:0] index;
  } log_entry_t;

  typedef enum logic {
    ST_EMPTY = 1'b0,
    ST_FULL  = 1'b1
  } stage_state_t;

  // Single-bit and parity-bit-only errors both count as corrected events.
  function automatic logic is_corrected(input logic [1:0] error_type);
    return (error_type == ERR_SINGLE) || (error_type == ERR_PARITY);
  endfunction

endpackage

// File: rtl/ecc_log_fifo.sv
// Synchronous show-ahead FIFO: rd_data always shows the head entry.
// A push into a full FIFO is accepted only when a pop frees a slot in the same cycle.
module ecc_log_fifo #(
  parameter int unsigned WIDTH = 14,
  parameter int unsigned DEPTH = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             push,
  input  logic             pop,
  input  logic [WIDTH-1:0] wr_data,
  output logic [WIDTH-1:0] rd_data,
  output logic             full,
  output logic             empty
);

  localparam int unsigned AW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW:0]      wr_ptr;
  logic [AW:0]      rd_ptr;
  logic             do_push;
  logic             do_pop;

  // Extra pointer MSB distinguishes full from empty when the addresses match.
  assign empty   = (wr_ptr == rd_ptr);
  assign full    = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
  assign do_pop  = pop && !empty;
  assign do_push = push && (!full || do_pop);

  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
    end
  end

  // NOTE: storage has no reset; the pointers define validity and the head is masked while empty.
  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr[AW-1:0]] <= wr_data;
  end

  assign rd_data = empty ? '0 : mem[rd_ptr[AW-1:0]];

endmodule

// File: rtl/ecc_error_monitor.sv
// One-deep registered stage after the SECDED decoder: forwards data, counts
// corrected/uncorrectable errors, logs error events and raises a policy interrupt.
module ecc_error_monitor
  import ecc_pkg::*;
#(
  parameter int unsigned CNT_W         = 16,
  parameter int unsigned IDX_W         = 8,
  parameter int unsigned LOG_DEPTH     = 4,
  parameter int unsigned SINGLE_THRESH = 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [DATA_W-1:0] in_data,
  input  logic [SYN_W-1:0]  in_syndrome,
  input  logic              in_word_parity,
  input  logic [1:0]        in_error_type,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] out_data,
  output logic              out_uncorrectable,
  input  logic              cnt_clear,
  output logic [CNT_W-1:0]  single_count,
  output logic [CNT_W-1:0]  double_count,
  input  logic              log_pop,
  output logic              log_valid,
  output logic [SYN_W-1:0]  log_syndrome,
  output logic [1:0]        log_error_type,
  output logic [IDX_W-1:0]  log_index,
  output logic              log_overflow,
  output logic              irq
);

  typedef struct packed {
    logic [SYN_W-1:0] syndrome;
    logic [1:0]       error_type;
    logic [IDX_W-1:0] index;
  } entry_t;

  localparam int unsigned ENTRY_W = $bits(entry_t);

  stage_state_t     state_q, state_d;
  logic             accept;
  logic             count_single;
  logic             count_double;
  logic [IDX_W-1:0] index_q;
  logic [CNT_W-1:0] single_d, double_d;
  logic             overflow_d;
  logic             irq_d;
  logic             log_push;
  logic             log_full;
  logic             log_empty;
  logic             log_drop;
  entry_t           push_entry;
  entry_t           head_entry;
  logic [ENTRY_W-1:0] fifo_rd;

  // Overall parity is already folded into error_type by the decoder.
  logic unused_parity;
  assign unused_parity = in_word_parity;

  assign in_ready     = !out_valid || out_ready;
  assign accept       = in_valid && in_ready;
  assign out_valid    = (state_q == ST_FULL);
  assign count_single = accept && is_corrected(in_error_type);
  assign count_double = accept && (in_error_type == ERR_DOUBLE);

  // NOTE: every always_comb output gets a default first so no path infers a latch.
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_EMPTY: if (accept) state_d = ST_FULL;
      ST_FULL:  if (out_ready && !accept) state_d = ST_EMPTY;
      default:  state_d = ST_EMPTY;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q           <= ST_EMPTY;
      out_data          <= '0;
      out_uncorrectable <= 1'b0;
      index_q           <= '0;
    end else begin
      state_q <= state_d;
      if (accept) begin
        out_data          <= in_data;
        out_uncorrectable <= (in_error_type == ERR_DOUBLE);
        index_q           <= index_q + 1'b1;
      end
    end
  end

  // A clear coincident with an event leaves that event counted.
  always_comb begin
    single_d = single_count;
    double_d = double_count;
    if (cnt_clear) begin
      single_d = count_single ? CNT_W'(1) : '0;
      double_d = count_double ? CNT_W'(1) : '0;
    end else begin
      if (count_single && (single_count != '1)) single_d = single_count + 1'b1;
      if (count_double && (double_count != '1)) double_d = double_count + 1'b1;
    end
  end

  assign log_push   = accept && (in_error_type != ERR_NONE);
  assign log_drop   = log_push && log_full && !log_pop;
  assign overflow_d = (cnt_clear ? 1'b0 : log_overflow) || log_drop;
  assign irq_d      = (double_d != '0) || (single_d >= CNT_W'(SINGLE_THRESH)) || overflow_d;

  always_ff @(posedge clk) begin
    if (rst) begin
      single_count <= '0;
      double_count <= '0;
      log_overflow <= 1'b0;
      irq          <= 1'b0;
    end else begin
      single_count <= single_d;
      double_count <= double_d;
      log_overflow <= overflow_d;
      irq          <= irq_d;
    end
  end

  always_comb begin
    push_entry            = '0;
    push_entry.syndrome   = in_syndrome;
    push_entry.error_type = in_error_type;
    push_entry.index      = index_q;
  end

  ecc_log_fifo #(
    .WIDTH(ENTRY_W),
    .DEPTH(LOG_DEPTH)
  ) u_log (
    .clk    (clk),
    .rst    (rst),
    .push   (log_push),
    .pop    (log_pop),
    .wr_data(push_entry),
    .rd_data(fifo_rd),
    .full   (log_full),
    .empty  (log_empty)
  );

  assign head_entry     = entry_t'(fifo_rd);
  assign log_valid      = !log_empty;
  assign log_syndrome   = head_entry.syndrome;
  assign log_error_type = head_entry.error_type;
  assign log_index      = head_entry.index;

endmodule

// File: tb/tb_ecc_error_monitor.sv
// Directed bench for ecc_error_monitor: scoreboard on the forwarded stream plus
// counter/log/irq checks on a default build and a narrow-counter build.
module tb_ecc_error_monitor;
  import ecc_pkg::*;

  logic       clk;
  logic       rst;
  logic       in_valid, in_ready, in_word_parity;
  logic [7:0] in_data;
  logic [3:0] in_syndrome;
  logic [1:0] in_error_type;
  logic       out_valid, out_ready, out_uncorrectable;
  logic [7:0] out_data;
  logic       cnt_clear, log_pop, log_valid, log_overflow, irq;
  logic [15:0] single_count, double_count;
  logic [3:0] log_syndrome;
  logic [1:0] log_error_type;
  logic [7:0] log_index;

  logic       in_valid4, in_ready4;
  logic [7:0] in_data4;
  logic [3:0] in_syndrome4;
  logic [1:0] in_error_type4;
  logic       out_valid4, out_ready4, out_uncorrectable4;
  logic [7:0] out_data4;
  logic       cnt_clear4, log_pop4, log_valid4, log_overflow4, irq4;
  logic [3:0] single_count4, double_count4;
  logic [3:0] log_syndrome4;
  logic [1:0] log_error_type4;
  logic [1:0] log_index4;

  typedef struct { logic [7:0] data; logic unc; } exp_t;
  exp_t exp_q[$];

  int checks = 0;
  int errors = 0;

  ecc_error_monitor dut (
    .clk(clk), .rst(rst),
    .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
    .in_syndrome(in_syndrome), .in_word_parity(in_word_parity), .in_error_type(in_error_type),
    .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
    .out_uncorrectable(out_uncorrectable), .cnt_clear(cnt_clear),
    .single_count(single_count), .double_count(double_count),
    .log_pop(log_pop), .log_valid(log_valid), .log_syndrome(log_syndrome),
    .log_error_type(log_error_type), .log_index(log_index),
    .log_overflow(log_overflow), .irq(irq)
  );

  ecc_error_monitor #(.CNT_W(4), .IDX_W(2)) dut4 (
    .clk(clk), .rst(rst),
    .in_valid(in_valid4), .in_ready(in_ready4), .in_data(in_data4),
    .in_syndrome(in_syndrome4), .in_word_parity(1'b0), .in_error_type(in_error_type4),
    .out_valid(out_valid4), .out_ready(out_ready4), .out_data(out_data4),
    .out_uncorrectable(out_uncorrectable4), .cnt_clear(cnt_clear4),
    .single_count(single_count4), .double_count(double_count4),
    .log_pop(log_pop4), .log_valid(log_valid4), .log_syndrome(log_syndrome4),
    .log_error_type(log_error_type4), .log_index(log_index4),
    .log_overflow(log_overflow4), .irq(irq4)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not complete");
    $fatal(1, "timeout");
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Settle inputs, run the scoreboard for the coming edge, then step past it.
  task automatic tick();
    exp_t e;
    #1;
    if (!rst) begin
      if (out_valid && out_ready) begin
        check("sb_has_expected", exp_q.size() != 0, 1);
        if (exp_q.size() != 0) begin
          e = exp_q.pop_front();
          check("sb_data", out_data, e.data);
          check("sb_uncorrectable", out_uncorrectable, e.unc);
        end
      end
      if (in_valid && in_ready) begin
        e.data = in_data;
        e.unc  = (in_error_type == ERR_DOUBLE);
        exp_q.push_back(e);
      end
    end
    @(posedge clk);
    #1;
  endtask

  initial begin
    logic [7:0] words [4];
    words[0] = 8'h11; words[1] = 8'h22; words[2] = 8'h33; words[3] = 8'h44;

    rst = 1'b1; in_valid = 0; in_data = 0; in_syndrome = 0; in_word_parity = 0;
    in_error_type = ERR_NONE; out_ready = 0; cnt_clear = 0; log_pop = 0;
    in_valid4 = 0; in_data4 = 0; in_syndrome4 = 0; in_error_type4 = ERR_NONE;
    out_ready4 = 1; cnt_clear4 = 0; log_pop4 = 0;

    // Reset state
    tick(); tick();
    rst = 1'b0; exp_q.delete();
    tick();
    check("rst_out_valid", out_valid, 0);
    check("rst_in_ready", in_ready, 1);
    check("rst_out_data", out_data, 0);
    check("rst_out_unc", out_uncorrectable, 0);
    check("rst_single", single_count, 0);
    check("rst_double", double_count, 0);
    check("rst_log_valid", log_valid, 0);
    check("rst_log_fields", {log_syndrome, log_error_type, log_index}, 0);
    check("rst_overflow", log_overflow, 0);
    check("rst_irq", irq, 0);

    // Error-free words, back to back
    out_ready = 1; in_valid = 1;
    for (int i = 0; i < 4; i++) begin
      in_data = words[i];
      tick();
      if (i == 0) begin
        check("lat_out_valid", out_valid, 1);
        check("lat_out_data", out_data, 8'h11);
      end
    end
    in_valid = 0;
    tick();
    check("clean_drained", exp_q.size(), 0);
    check("clean_single", single_count, 0);
    check("clean_double", double_count, 0);
    check("clean_log_valid", log_valid, 0);
    check("clean_irq", irq, 0);

    // Reset while a word is held
    out_ready = 0; in_valid = 1; in_data = 8'h99;
    tick();
    in_valid = 0;
    check("hold_out_data", out_data, 8'h99);
    rst = 1; tick(); rst = 0; exp_q.delete();
    check("midrst_out_valid", out_valid, 0);
    check("midrst_out_data", out_data, 0);

    // Third word after reset carries a single error
    out_ready = 1; in_valid = 1;
    in_data = 8'h11; tick();
    in_data = 8'h22; tick();
    in_data = 8'h5A; in_error_type = ERR_SINGLE; in_syndrome = 4'h6; tick();
    in_valid = 0; in_error_type = ERR_NONE;
    tick();
    check("single_count_1", single_count, 1);
    check("log_head_valid", log_valid, 1);
    check("log_head_syn", log_syndrome, 4'h6);
    check("log_head_type", log_error_type, ERR_SINGLE);
    check("log_head_index", log_index, 2);
    check("single_no_irq", irq, 0);

    // Uncorrectable word, then counter clear
    in_valid = 1; in_data = 8'h77; in_error_type = ERR_DOUBLE; in_syndrome = 4'hC;
    tick();
    in_valid = 0; in_error_type = ERR_NONE;
    check("dbl_out_unc", out_uncorrectable, 1);
    check("dbl_count", double_count, 1);
    check("dbl_irq", irq, 1);
    cnt_clear = 1; tick(); cnt_clear = 0;
    check("clr_single", single_count, 0);
    check("clr_double", double_count, 0);
    check("clr_irq", irq, 0);
    check("clr_log_kept", log_valid, 1);
    check("clr_log_syn", log_syndrome, 4'h6);

    // Drain the log, including a pop while empty
    log_pop = 1;
    tick();
    check("pop_head_syn", log_syndrome, 4'hC);
    check("pop_head_type", log_error_type, ERR_DOUBLE);
    check("pop_head_index", log_index, 3);
    tick();
    check("pop_empty", log_valid, 0);
    tick();
    check("pop_while_empty", log_valid, 0);
    check("pop_empty_fields", log_syndrome, 0);
    log_pop = 0;

    // Backpressure: hold out_ready low for five cycles
    out_ready = 0; in_valid = 1; in_data = 8'hA1;
    tick();
    check("bp_in_ready", in_ready, 0);
    check("bp_out_data", out_data, 8'hA1);
    in_data = 8'hA2;
    for (int i = 0; i < 4; i++) begin
      tick();
      check("bp_hold_valid", out_valid, 1);
      check("bp_hold_data", out_data, 8'hA1);
    end
    out_ready = 1;
    tick();
    check("bp_next_data", out_data, 8'hA2);
    in_valid = 0;
    tick();
    check("bp_drained", exp_q.size(), 0);

    // Five logged errors with no pops: one dropped
    in_valid = 1; in_error_type = ERR_SINGLE;
    for (int i = 1; i <= 5; i++) begin
      in_data = 8'hB0 + 8'(i); in_syndrome = 4'(i);
      tick();
    end
    in_valid = 0;
    check("ovf_flag", log_overflow, 1);
    check("ovf_irq", irq, 1);
    check("ovf_single", single_count, 5);
    check("ovf_log_valid", log_valid, 1);
    check("ovf_head_syn", log_syndrome, 1);
    check("ovf_head_index", log_index, 6);

    // Push and pop together while full
    in_valid = 1; in_data = 8'hB7; in_syndrome = 4'h7; log_pop = 1;
    tick();
    in_valid = 0;
    check("pp_log_valid", log_valid, 1);
    check("pp_head_syn", log_syndrome, 2);
    check("pp_single", single_count, 6);
    tick(); tick(); tick();
    check("pp_kept_syn", log_syndrome, 4'h7);
    check("pp_kept_index", log_index, 11);
    tick();
    check("pp_emptied", log_valid, 0);
    log_pop = 0;

    // Threshold boundary, log kept from overflowing by concurrent pops
    cnt_clear = 1; tick(); cnt_clear = 0;
    check("clr2_overflow", log_overflow, 0);
    check("clr2_irq", irq, 0);
    in_valid = 1; in_syndrome = 4'h3; in_data = 8'hC3; log_pop = 1;
    tick();
    check("pp_empty_push", log_valid, 1);
    for (int i = 0; i < 6; i++) tick();
    check("thr7_single", single_count, 7);
    check("thr7_irq", irq, 0);
    tick();
    check("thr8_single", single_count, 8);
    check("thr8_irq", irq, 1);
    check("thr8_overflow", log_overflow, 0);
    in_valid = 0; in_error_type = ERR_NONE;
    tick();
    log_pop = 0;
    check("thr_log_empty", log_valid, 0);
    check("thr_drained", exp_q.size(), 0);

    // Narrow build: saturation, clear coincident with an event, index wrap
    in_valid4 = 1; in_error_type4 = ERR_SINGLE;
    for (int i = 0; i < 17; i++) begin
      in_data4 = 8'(i); in_syndrome4 = 4'(i);
      tick();
    end
    check("sat_single", single_count4, 15);
    check("sat_double", double_count4, 0);
    check("sat_overflow", log_overflow4, 1);
    in_syndrome4 = 4'hE; cnt_clear4 = 1; log_pop4 = 1;
    tick();
    in_valid4 = 0; cnt_clear4 = 0;
    check("clr_event_single", single_count4, 1);
    check("clr_event_overflow", log_overflow4, 0);
    check("w_head_syn", log_syndrome4, 1);
    check("w_head_index", log_index4, 1);
    tick(); tick(); tick();
    log_pop4 = 0;
    check("wrap_syn", log_syndrome4, 4'hE);
    check("wrap_index", log_index4, 1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/ecc_error_monitor.md
Name: ecc_error_monitor

Overview:
- Streaming stage directly downstream of the Hamming SECDED decoder (8 data bits, 13-bit codeword).
- Accepts each decoded word with its syndrome/parity/error_type and forwards the data through a one-deep registered valid/ready stage, flagging uncorrectable words.
- Keeps saturating single/double error counters and a small FIFO log of error events (syndrome, type, word index) for software.
- Raises an interrupt when policy thresholds are hit.

Parameters:
- CNT_W, 16, width of the error counters (saturating).
- IDX_W, 8, width of the word index counter (wraps).
- LOG_DEPTH, 4, error log FIFO entries (power of 2, >=2).
- SINGLE_THRESH, 8, single-error count at or above which irq asserts.

Ports:
- clk  in  1  clock, all state on rising edge.
- rst  in  1  synchronous, active-high reset.
- in_valid  in  1  decoded word present.
- in_ready  out  1  stage can accept.
- in_data  in  8  corrected data from decoder.
- in_syndrome  in  4  decoder syndrome.
- in_word_parity  in  1  decoder overall parity result.
- in_error_type  in  2  00 none, 01 single corrected, 10 double uncorrectable, 11 overall-parity-bit-only error.
- out_valid  out  1  forwarded word valid.
- out_ready  in  1  consumer accepts.
- out_data  out  8  forwarded data.
- out_uncorrectable  out  1  forwarded word had error_type 10.
- cnt_clear  in  1  clears counters and log_overflow.
- single_count  out  CNT_W  corrected-error count (types 01 and 11).
- double_count  out  CNT_W  uncorrectable-error count (type 10).
- log_pop  in  1  consume log head.
- log_valid  out  1  log non-empty.
- log_syndrome  out  4  head entry syndrome.
- log_error_type  out  2  head entry type.
- log_index  out  IDX_W  head entry word index.
- log_overflow  out  1  sticky: an error event was dropped.
- irq  out  1  interrupt.

Behaviour:
- Reset values: out_valid=0, out_data=0, out_uncorrectable=0, counts=0, word index=0, log empty (log_valid=0, head fields 0), log_overflow=0, irq=0. in_ready=1 after reset.
- Accept when in_valid && in_ready.
- in_ready = !out_valid || out_ready (combinational).
- Latency 1 cycle: the accepted word appears on out_* the next cycle. out_* stay stable while out_valid && !out_ready.
- Back-to-back throughput is 1 word/cycle when out_ready=1.
- Word index: increments by 1 per accepted word (including error-free words) and wraps from 2^IDX_W-1 to 0. A logged entry carries the index value before the increment.
- Counters (update on accept only):
  - types 01/11 increment single_count; type 10 increments double_count.
  - Both saturate at all-ones.
  - cnt_clear in the same cycle as a counted event leaves the counter at 1; otherwise it sets 0.
- Log FIFO, show-ahead:
  - Push on accept with in_error_type != 00.
  - log_pop with log_valid removes the head next cycle. log_pop while empty is ignored.
  - Push while full: entry dropped, log_overflow set.
  - Push and pop in the same cycle while full: no drop, count unchanged.
  - Push and pop in the same cycle while empty: entry written, log_valid=1 next cycle.
  - log_overflow is sticky until cnt_clear or rst. cnt_clear does not empty the FIFO.
- irq registered: next-state = (double_count_next != 0) || (single_count_next >= SINGLE_THRESH) || log_overflow_next. It therefore asserts the cycle after the triggering accept and deasserts the cycle after cnt_clear, unless re-triggered.
- Control is a 2-state output register (EMPTY/FULL):
  - EMPTY -> FULL on accept.
  - FULL -> EMPTY on out_ready && !accept.
  - FULL stays FULL on accept && out_ready (new word loaded).
- rst mid-transfer discards the held word and all log entries; no partial state survives.

Decomposition:
- Package ecc_pkg: error_type localparams ERR_NONE=2'b00, ERR_SINGLE=2'b01, ERR_DOUBLE=2'b10, ERR_PARITY=2'b11; DATA_W=8, SYN_W=4, CODE_W=13; packed log entry typedef {syndrome, error_type, index}.
- Sub-module ecc_log_fifo: parameterised sync FIFO with show-ahead head, push/pop/full/empty. Counters, index and output stage live in the top.

Test Plan:
- Reset, then 4 error-free words 0x11,0x22,0x33,0x44, out_ready=1 -> each appears 1 cycle later in order; counts 0; log_valid=0; irq=0.
- Word 0x5A, type 01, syndrome 0x6, sent as 3rd word after reset -> single_count=1; log head {0x6, 01, index 2}; out_uncorrectable=0.
- Type 10 word -> out_uncorrectable=1, double_count=1, irq=1 next cycle; cnt_clear -> counts 0, irq=0 the following cycle, log entry still present.
- Hold out_ready=0 for 5 cycles with in_valid=1 -> in_ready=0 after the first accept, out_data stable, no duplicate or lost word when out_ready returns.
- With no pops, 5 type-01 errors -> 4 logged, log_overflow=1, irq=1. Then push+pop in the same cycle while full -> no further drop, log_valid stays 1.
- Force single_count to all-ones via 2^CNT_W events (CNT_W=4 build) -> holds 15. cnt_clear coincident with a type-01 word -> single_count=1.
